// File: rtl/host_mem_sequencer.sv
// host_mem_sequencer
//   Host-link loader/dumper for a CPU-owned synchronous RAM.
//   IDLE -> LOAD: bytes from the host are packed LSB-first into DATA_W words
//                 and written to RAM words 0..DEPTH-1.
//   LOAD -> RUN : the CPU owns the RAM port (pass-through) until cpu_done.
//   RUN -> DUMP : RAM words 0..DEPTH-1 are read back and streamed LSB-first
//                 over a valid/ready byte link, then back to IDLE.
//   Optional build macro SEQ_CHECKSUM_EN: append one XOR checksum byte of all
//   dumped bytes after the last data byte.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   rx_data/rx_valid             inbound byte strobe
//   tx_data/tx_valid/tx_ready    outbound byte handshake
//   cpu_addr/cpu_wdata/cpu_we    CPU RAM port (honoured only in RUN)
//   cpu_run/cpu_done             CPU permission / end-of-program
//   mem_addr/mem_wdata/mem_we    RAM port, mem_rdata one cycle after address
//   state                        IDLE=0 LOAD=1 RUN=2 DUMP=3
module host_mem_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic              cpu_run,
    input  logic              cpu_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state
);
    localparam int BPW = DATA_W / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BW-1:0]   LAST_BYTE = BW'(BPW - 1);
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] NWORDS    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    state_t st, st_nx;

    logic [BW-1:0]     byte_cnt;
    logic [ADDR_W:0]   word_cnt;   // one extra bit so DEPTH == 2^ADDR_W is reachable
    logic [DATA_W-1:0] asm_q, asm_nx;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_pend;
    logic [DATA_W-1:0] shreg;
    logic [1:0]        rd_pipe;    // [0]: address presented, [1]: rdata valid

    logic take_byte, last_byte, last_word, accept, dump_done;

`ifdef SEQ_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_phase;
    assign tx_data = csum_phase ? csum : shreg[7:0];
`else
    assign tx_data = shreg[7:0];
`endif

    assign state     = st;
    assign cpu_run   = (st == S_RUN);
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_word = (word_cnt == LAST_WORD);
    assign accept    = tx_valid & tx_ready;
    // Bytes arriving after the last word is complete (while its write drains)
    // are dropped so no address >= DEPTH is ever written.
    assign take_byte = rx_valid && (st == S_IDLE || st == S_LOAD) && (word_cnt < NWORDS);

`ifdef SEQ_CHECKSUM_EN
    assign dump_done = accept && csum_phase;
`else
    assign dump_done = accept && last_byte && last_word;
`endif

    always_comb begin
        asm_nx = asm_q;
        asm_nx[{byte_cnt, 3'b000} +: 8] = rx_data;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            S_IDLE: if (rx_valid) st_nx = S_LOAD;
            // The final write is in flight when word_cnt has already reached DEPTH.
            S_LOAD: if (wr_pend && word_cnt == NWORDS) st_nx = S_RUN;
            S_RUN:  if (cpu_done) st_nx = S_DUMP;
            S_DUMP: if (dump_done) st_nx = S_IDLE;
            default: st_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        unique case (st)
            S_LOAD: begin
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                mem_we    = wr_pend;
            end
            S_RUN: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            S_DUMP: mem_addr = word_cnt[ADDR_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            byte_cnt <= '0;
            word_cnt <= '0;
            asm_q    <= '0;
            wr_data  <= '0;
            wr_addr  <= '0;
            wr_pend  <= 1'b0;
            shreg    <= '0;
            rd_pipe  <= '0;
            tx_valid <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            st      <= st_nx;
            wr_pend <= 1'b0;
            rd_pipe <= {rd_pipe[0], 1'b0};
            unique case (st)
                S_IDLE, S_LOAD: begin
                    if (take_byte) begin
                        if (last_byte) begin
                            // Completed word goes to a separate write register so the
                            // next byte can be assembled during the write cycle.
                            wr_pend  <= 1'b1;
                            wr_addr  <= word_cnt[ADDR_W-1:0];
                            wr_data  <= asm_nx;
                            word_cnt <= word_cnt + 1'b1;
                            byte_cnt <= '0;
                            asm_q    <= '0;
                        end else begin
                            asm_q    <= asm_nx;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (cpu_done) begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        rd_pipe  <= 2'b01;
`ifdef SEQ_CHECKSUM_EN
                        csum <= '0;
`endif
                    end
                end
                S_DUMP: begin
                    if (rd_pipe[1]) begin
                        shreg    <= mem_rdata;
                        tx_valid <= 1'b1;
                    end
`ifdef SEQ_CHECKSUM_EN
                    if (accept && csum_phase) begin
                        tx_valid   <= 1'b0;
                        csum_phase <= 1'b0;
                        csum       <= '0;
                        word_cnt   <= '0;
                    end else
`endif
                    if (accept) begin
                        shreg <= shreg >> 8;
`ifdef SEQ_CHECKSUM_EN
                        csum <= csum ^ shreg[7:0];
`endif
                        if (last_byte) begin
                            byte_cnt <= '0;
                            if (last_word) begin
`ifdef SEQ_CHECKSUM_EN
                                csum_phase <= 1'b1;   // tx_valid stays up for the checksum
`else
                                tx_valid <= 1'b0;
                                word_cnt <= '0;
`endif
                            end else begin
                                // Next word is read only once this one has fully drained.
                                tx_valid <= 1'b0;
                                word_cnt <= word_cnt + 1'b1;
                                rd_pipe  <= 2'b01;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_mem_sequencer.sv
module tb_host_mem_sequencer;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_run;
    logic          cpu_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    state;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_b [0:8];

    host_mem_sequencer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_run(cpu_run), .cpu_done(cpu_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .state(state)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the address.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        cpu_addr = 8'h05; cpu_wdata = 16'h1234; cpu_we = 1'b1; cpu_done = 1'b0;
        #3;
        checks++; if (state !== 2'd0) $display("FAIL reset_state got=%0d want=0", state); else passed++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b want=0", tx_valid); else passed++;
        checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b want=0", mem_we); else passed++;
        checks++; if (cpu_run !== 1'b0) $display("FAIL reset_cpu_run got=%b want=0", cpu_run); else passed++;
        checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr got=%h want=0", mem_addr); else passed++;
        tick(); tick();
        @(negedge clk); rst_n = 1'b1;
        tick();
        // cpu_we must be ignored outside RUN, cpu_done too
        cpu_done = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) $display("FAIL idle_cpu_we_ignored got=%b want=0", mem_we); else passed++;
        tick();
        checks++; if (state !== 2'd0) $display("FAIL idle_cpu_done_ignored got=%0d want=0", state); else passed++;
        cpu_we = 1'b0; cpu_done = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        for (int c = 0; c < 3; c++) begin
            rx_valid = 1'b1; rx_data = 8'hA1 + 8'(c);
            tick();
        end
        rx_valid = 1'b0;
        #1;
        checks++; if (state !== 2'd1) $display("FAIL midload_state got=%0d want=1", state); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) $display("FAIL midload_reset_state got=%0d want=0", state); else passed++;
        checks++; if (mem_we !== 1'b0) $display("FAIL midload_reset_mem_we got=%b want=0", mem_we); else passed++;
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    // Bytes step*1 .. step*8 back to back; word w written at cycle 2w+2, RUN at cycle 9.
    task automatic do_load(input logic [7:0] step, input logic hold_done);
        logic [7:0] lo, hi;
        for (int c = 0; c < 10; c++) begin
            rx_valid = (c < 8);
            rx_data  = 8'(step * (c + 1));
            cpu_done = hold_done && (c < 9);
            #1;
            if (c >= 2 && c <= 8 && (c % 2) == 0) begin
                lo = 8'(step * (c - 1));
                hi = 8'(step * c);
                checks++; if (mem_we !== 1'b1) $display("FAIL load_we c=%0d got=%b want=1", c, mem_we); else passed++;
                checks++; if (mem_addr !== AW'(c / 2 - 1)) $display("FAIL load_addr c=%0d got=%0d want=%0d", c, mem_addr, c / 2 - 1); else passed++;
                checks++; if (mem_wdata !== {hi, lo}) $display("FAIL load_wdata c=%0d got=%h want=%h", c, mem_wdata, {hi, lo}); else passed++;
            end else begin
                checks++; if (mem_we !== 1'b0) $display("FAIL load_no_we c=%0d got=%b want=0", c, mem_we); else passed++;
            end
            if (c == 1) begin
                checks++; if (state !== 2'd1) $display("FAIL load_state c=1 got=%0d want=1", state); else passed++;
            end
            if (c == 9) begin
                checks++; if (state !== 2'd2) $display("FAIL load_to_run got=%0d want=2", state); else passed++;
            end
            tick();
        end
        rx_valid = 1'b0; cpu_done = 1'b0;
    endtask

    task automatic test_run();
        cpu_we = 1'b1; cpu_addr = 8'd3; cpu_wdata = 16'hBEEF;
        rx_valid = 1'b1; rx_data = 8'h99;
        #1;
        checks++; if (cpu_run !== 1'b1) $display("FAIL run_cpu_run got=%b want=1", cpu_run); else passed++;
        checks++; if (mem_we !== 1'b1) $display("FAIL run_mem_we got=%b want=1", mem_we); else passed++;
        checks++; if (mem_addr !== 8'd3) $display("FAIL run_mem_addr got=%0d want=3", mem_addr); else passed++;
        checks++; if (mem_wdata !== 16'hBEEF) $display("FAIL run_mem_wdata got=%h want=beef", mem_wdata); else passed++;
        tick();
        cpu_we = 1'b0; rx_valid = 1'b0;
        #1;
        checks++; if (state !== 2'd2) $display("FAIL run_rx_ignored got=%0d want=2", state); else passed++;
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        #1;
        checks++; if (state !== 2'd3) $display("FAIL run_to_dump got=%0d want=3", state); else passed++;
        checks++; if (cpu_run !== 1'b0) $display("FAIL dump_cpu_run got=%b want=0", cpu_run); else passed++;
    endtask

    task automatic do_dump(input int nbytes, input int stall);
        int n;
        int k;
        bit seen;
        tx_ready = 1'b0;
        seen = 1'b0;
        for (k = 0; k < 10 && !seen; k++) begin
            if (tx_valid === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen) $display("FAIL dump_first_valid got=timeout want=tx_valid"); else passed++;
        for (int s = 0; s < stall; s++) begin
            rx_valid = 1'b1; rx_data = 8'h5A;
            #1;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[0])
                $display("FAIL dump_stall s=%0d got=%b/%h want=1/%h", s, tx_valid, tx_data, exp_b[0]);
            else passed++;
            tick();
        end
        rx_valid = 1'b0;
        checks++; if (state !== 2'd3) $display("FAIL dump_rx_ignored got=%0d want=3", state); else passed++;
        n = 0;
        for (k = 0; k < 200 && n < nbytes; k++) begin
            tx_ready = ((k % 3) != 2);
            #1;
            if (tx_valid === 1'b1 && tx_ready) begin
                checks++;
                if (tx_data !== exp_b[n]) $display("FAIL dump_byte n=%0d got=%h want=%h", n, tx_data, exp_b[n]);
                else passed++;
                n++;
            end
            tick();
        end
        tx_ready = 1'b0;
        #1;
        checks++; if (n != nbytes) $display("FAIL dump_count got=%0d want=%0d", n, nbytes); else passed++;
        checks++; if (state !== 2'd0) $display("FAIL dump_to_idle got=%0d want=0", state); else passed++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL dump_idle_tx_valid got=%b want=0", tx_valid); else passed++;
    endtask

    task automatic test_dump_modified();
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        exp_b[4] = 8'h55; exp_b[5] = 8'h66; exp_b[6] = 8'hEF; exp_b[7] = 8'hBE;
        exp_b[8] = 8'h26;
`ifdef SEQ_CHECKSUM_EN
        do_dump(9, 5);
`else
        do_dump(8, 5);
`endif
    endtask

    task automatic test_second_session();
        do_load(8'h01, 1'b0);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        for (int i = 0; i < 8; i++) exp_b[i] = 8'(i + 1);
        exp_b[8] = 8'h08;
`ifdef SEQ_CHECKSUM_EN
        do_dump(9, 0);
`else
        do_dump(8, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        do_load(8'h11, 1'b1);   // cpu_done held high during LOAD must be ignored
        test_run();
        test_dump_modified();
        tick();
        test_second_session();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
